// File: rtl/serial_alu_core.sv
// serial_alu_core: bit-serial ALU slave for the mini serial processor.
//
// A request packet {op_2, op_1, op_code} arrives LSB first on spi_mosi after
// a start bit (mosi=1 while nss=0). The ALU result and the flags
// {E, V, C, N, Z} are returned LSB first on spi_miso. A bit-by-bit copy of
// the request is captured, evaluated in one cycle and shifted back out.
//
// Ports:
//   i_clock   in   system clock
//   i_reset   in   asynchronous active-low reset
//   spi_nss   in   slave select, active-low
//   spi_mosi  in   master-out serial data
//   spi_miso  out  slave-out serial data
//   o_busy    out  high in any state other than IDLE
//
// Optional feature: define SERIAL_ALU_MUL_EN to build opcode 10 as an
// unsigned multiply. Without it, no multiplier exists and opcode 10 is
// reported as illegal.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for start bit (nss=0, mosi=1)
// RECEIVING | capturing PACKET_BITS request bits, one per clock
// OPERATE   | one cycle: result and flags registered into response
// READY     | miso=1 (when selected); mosi=0 with nss=0 starts the reply
// SENDING   | shifting RESP_BITS response bits out on miso

module serial_alu_core #(
  parameter int DATA_WIDTH = 8,
  parameter int OP_WIDTH   = 4
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic spi_nss,
  input  logic spi_mosi,
  output logic spi_miso,
  output logic o_busy
);

  localparam int PACKET_BITS = OP_WIDTH + 2*DATA_WIDTH;
  localparam int RESP_BITS   = DATA_WIDTH + 5;
  localparam int CIN_W       = $clog2(PACKET_BITS);
  localparam int COUT_W      = $clog2(RESP_BITS);
  localparam int SH_W        = $clog2(DATA_WIDTH);
  localparam int MSB         = DATA_WIDTH - 1;

  localparam logic [OP_WIDTH-1:0] OP_ADD  = OP_WIDTH'(0);
  localparam logic [OP_WIDTH-1:0] OP_SUB  = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] OP_AND  = OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0] OP_OR   = OP_WIDTH'(3);
  localparam logic [OP_WIDTH-1:0] OP_XOR  = OP_WIDTH'(4);
  localparam logic [OP_WIDTH-1:0] OP_SLL  = OP_WIDTH'(5);
  localparam logic [OP_WIDTH-1:0] OP_SRL  = OP_WIDTH'(6);
  localparam logic [OP_WIDTH-1:0] OP_SRA  = OP_WIDTH'(7);
  localparam logic [OP_WIDTH-1:0] OP_SLT  = OP_WIDTH'(8);
  localparam logic [OP_WIDTH-1:0] OP_SLTU = OP_WIDTH'(9);
`ifdef SERIAL_ALU_MUL_EN
  localparam logic [OP_WIDTH-1:0] OP_MUL  = OP_WIDTH'(10);
`endif

  typedef enum logic [2:0] {
    IDLE,
    RECEIVING,
    OPERATE,
    READY,
    SENDING
  } state_t;

  state_t state, state_next;

  logic [CIN_W-1:0]       counter_in;
  logic [COUT_W-1:0]      counter_out;
  logic [PACKET_BITS-1:0] req;
  logic [RESP_BITS-1:0]   resp;

  logic last_in;
  logic last_out;

  assign last_in  = (counter_in  == CIN_W'(PACKET_BITS - 1));
  assign last_out = (counter_out == COUT_W'(RESP_BITS - 1));

  // Request field split
  logic [OP_WIDTH-1:0]   op_code;
  logic [DATA_WIDTH-1:0] op_1;
  logic [DATA_WIDTH-1:0] op_2;
  logic [SH_W-1:0]       shamt;

  assign op_code = req[OP_WIDTH-1:0];
  assign op_1    = req[OP_WIDTH +: DATA_WIDTH];
  assign op_2    = req[OP_WIDTH+DATA_WIDTH +: DATA_WIDTH];
  assign shamt   = op_2[SH_W-1:0];

  // Widened by one bit so the top bit is the carry (ADD) or borrow (SUB).
  logic [DATA_WIDTH:0] sum;
  logic [DATA_WIDTH:0] diff;

  assign sum  = {1'b0, op_1} + {1'b0, op_2};
  assign diff = {1'b0, op_1} - {1'b0, op_2};

`ifdef SERIAL_ALU_MUL_EN
  logic [2*DATA_WIDTH-1:0] prod;
  assign prod = op_1 * op_2;
`endif

  logic [DATA_WIDTH-1:0] result;
  logic flag_z, flag_n, flag_c, flag_v, flag_e;

  always_comb begin
    result = '0;
    flag_c = 1'b0;
    flag_v = 1'b0;
    flag_e = 1'b0;
    case (op_code)
      OP_ADD: begin
        result = sum[MSB:0];
        flag_c = sum[DATA_WIDTH];
        flag_v = (op_1[MSB] == op_2[MSB]) && (sum[MSB] != op_1[MSB]);
      end
      OP_SUB: begin
        result = diff[MSB:0];
        flag_c = diff[DATA_WIDTH];
        flag_v = (op_1[MSB] != op_2[MSB]) && (diff[MSB] != op_1[MSB]);
      end
      OP_AND:  result = op_1 & op_2;
      OP_OR:   result = op_1 | op_2;
      OP_XOR:  result = op_1 ^ op_2;
      OP_SLL:  result = op_1 << shamt;
      OP_SRL:  result = op_1 >> shamt;
      OP_SRA:  result = $unsigned($signed(op_1) >>> shamt);
      OP_SLT:  result = {{(DATA_WIDTH-1){1'b0}}, ($signed(op_1) < $signed(op_2))};
      OP_SLTU: result = {{(DATA_WIDTH-1){1'b0}}, (op_1 < op_2)};
`ifdef SERIAL_ALU_MUL_EN
      OP_MUL: begin
        result = prod[MSB:0];
        flag_c = |prod[2*DATA_WIDTH-1:DATA_WIDTH];
      end
`endif
      default: flag_e = 1'b1;
    endcase
    // Illegal opcodes report only E; Z is suppressed even though result is 0.
    flag_z = ~flag_e & (result == '0);
    flag_n = result[MSB];
  end

  // State register
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and outputs
  always_comb begin
    state_next = state;
    spi_miso   = 1'b0;
    o_busy     = (state != IDLE);
    case (state)
      IDLE: begin
        if (!spi_nss && spi_mosi) state_next = RECEIVING;
      end
      RECEIVING: begin
        if (spi_nss)      state_next = IDLE;
        else if (last_in) state_next = OPERATE;
      end
      OPERATE: begin
        state_next = READY;
      end
      READY: begin
        spi_miso = ~spi_nss;
        if (!spi_nss && !spi_mosi) state_next = SENDING;
      end
      SENDING: begin
        spi_miso = ~spi_nss & resp[counter_out];
        if (spi_nss || last_out) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Shift counters and request/response storage
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      counter_in  <= '0;
      counter_out <= '0;
      req         <= '0;
      resp        <= '0;
    end else begin
      case (state)
        RECEIVING: begin
          if (spi_nss) begin
            counter_in <= '0;
          end else begin
            req[counter_in] <= spi_mosi;
            counter_in      <= last_in ? '0 : counter_in + CIN_W'(1);
          end
        end
        OPERATE: begin
          resp <= {flag_e, flag_v, flag_c, flag_n, flag_z, result};
        end
        SENDING: begin
          counter_out <= (spi_nss || last_out) ? '0 : counter_out + COUT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
